// File: rtl/level_bar_meter.sv
// LED bar-graph level meter framed by an asynchronous divided clock treated as data.
// Optional peak-hold/decay marker is built when PEAK_HOLD_EN is defined.
module level_bar_meter #(
  parameter int unsigned NUM_LEDS   = 10,
  parameter int unsigned LEVEL_W    = 8,
  parameter int unsigned HOLD_TICKS = 50,
  parameter int unsigned DECAY_STEP = 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              newClock,
  input  logic [LEVEL_W-1:0]                level,
  input  logic                              levelValid,
  output logic                              tickPulse,
  output logic [NUM_LEDS-1:0]               ledBar,
  output logic [$clog2(NUM_LEDS+1)-1:0]     peakIndex
);

  localparam int unsigned PeakW = $clog2(NUM_LEDS + 1);
  localparam int unsigned ProdW = LEVEL_W + $clog2(NUM_LEDS + 2);

  if (NUM_LEDS < 2 || NUM_LEDS > 32) begin : g_bad_num_leds
    $error("NUM_LEDS must be within 2..32");
  end
  if (HOLD_TICKS < 1 || HOLD_TICKS > 255) begin : g_bad_hold_ticks
    $error("HOLD_TICKS must be within 1..255");
  end
  if (DECAY_STEP < 1) begin : g_bad_decay_step
    $error("DECAY_STEP must be at least 1");
  end

  logic [2:0]          sync_q;
  logic                tick_q;
  logic                update_q;
  logic [LEVEL_W-1:0]  acc_q;
  logic [LEVEL_W-1:0]  acc_max;
  logic [LEVEL_W-1:0]  sample;
  logic [LEVEL_W-1:0]  frame_level_q;
  logic [ProdW-1:0]    prod;
  logic [ProdW-1:0]    quot;
  logic [PeakW-1:0]    bar_count;
  logic [NUM_LEDS-1:0] therm;
  logic [NUM_LEDS-1:0] led_d;
  logic [NUM_LEDS-1:0] led_q;

  // Synchroniser resets high so a newClock already high at release never ticks.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q   <= 3'b111;
      tick_q   <= 1'b0;
      update_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[1:0], newClock};
      tick_q   <= sync_q[1] & ~sync_q[2];
      update_q <= tick_q;
    end
  end

  always_comb begin
    sample  = levelValid ? level : '0;
    acc_max = (sample > acc_q) ? sample : acc_q;
  end

  // A sample on the tick cycle closes into the ending frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q         <= '0;
      frame_level_q <= '0;
    end else if (tick_q) begin
      acc_q         <= '0;
      frame_level_q <= acc_max;
    end else begin
      acc_q         <= acc_max;
    end
  end

  always_comb begin
    prod      = ProdW'(frame_level_q) * ProdW'(NUM_LEDS + 1);
    quot      = prod >> LEVEL_W;
    bar_count = (quot > ProdW'(NUM_LEDS)) ? PeakW'(NUM_LEDS) : PeakW'(quot);
    therm     = '0;
    for (int i = 0; i < int'(NUM_LEDS); i++) begin
      therm[i] = (i < int'(bar_count));
    end
  end

`ifdef PEAK_HOLD_EN
  typedef enum logic [1:0] {StIdle, StHold, StDecay} state_e;

  state_e           state_q, state_d;
  logic [PeakW-1:0] peak_q, peak_d, peak_dec;
  logic [7:0]       hold_cnt_q, hold_cnt_d;

  always_comb begin
    state_d    = state_q;
    peak_d     = peak_q;
    hold_cnt_d = hold_cnt_q;
    peak_dec   = '0;
    led_d      = '0;
    if (int'(peak_q) > int'(DECAY_STEP)) begin
      peak_dec = peak_q - PeakW'(DECAY_STEP);
    end
    if (update_q) begin
      if (bar_count >= peak_q && bar_count != '0) begin
        peak_d     = bar_count;
        hold_cnt_d = 8'(HOLD_TICKS);
        state_d    = StHold;
      end else begin
        case (state_q)
          StIdle: peak_d = '0;
          StHold: begin
            if (hold_cnt_q != 8'd0) begin
              hold_cnt_d = hold_cnt_q - 8'd1;
            end else begin
              peak_d  = peak_dec;
              state_d = StDecay;
            end
          end
          StDecay: begin
            peak_d = peak_dec;
            if (peak_dec == '0) state_d = StIdle;
          end
          default: state_d = StIdle;
        endcase
      end
    end
    for (int i = 0; i < int'(NUM_LEDS); i++) begin
      led_d[i] = therm[i] | (int'(peak_d) == i + 1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      peak_q     <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      peak_q     <= peak_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign peakIndex = peak_q;
`else
  always_comb begin
    led_d = therm;
  end

  assign peakIndex = '0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      led_q <= '0;
    end else if (update_q) begin
      led_q <= led_d;
    end
  end

  assign tickPulse = tick_q;
  assign ledBar    = led_q;

endmodule

// File: tb/tb_level_bar_meter.sv
// Self-checking bench for level_bar_meter: frame-level reference model with randomized samples.
// The peak-marker expectations follow PEAK_HOLD_EN like the design does.
module tb_level_bar_meter;

  localparam int N    = 10;
  localparam int W    = 8;
  localparam int HOLD = 3;
  localparam int DEC  = 1;

  logic         clock = 1'b0;
  logic         reset;
  logic         newClock;
  logic [W-1:0] level;
  logic         levelValid;
  logic         tickPulse;
  logic [N-1:0] ledBar;
  logic [3:0]   peakIndex;

  int checks = 0;
  int passed = 0;

  // Reference model state: peak as "value set, frames since set".
  int           pk_cur;
  int           pk_set;
  int           since;
  logic [N-1:0] exp_led;
  int           exp_pk;
  int           samp_q[$];

  level_bar_meter #(
    .NUM_LEDS  (N),
    .LEVEL_W   (W),
    .HOLD_TICKS(HOLD),
    .DECAY_STEP(DEC)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .newClock  (newClock),
    .level     (level),
    .levelValid(levelValid),
    .tickPulse (tickPulse),
    .ledBar    (ledBar),
    .peakIndex (peakIndex)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int bar_of(input int lv);
    int b;
    b = (lv * (N + 1)) / (1 << W);
    if (b > N) b = N;
    return b;
  endfunction

  function automatic void model_reset();
    pk_cur  = 0;
    pk_set  = 0;
    since   = 0;
    exp_led = '0;
    exp_pk  = 0;
  endfunction

  function automatic void model_frame(input int bar);
    logic [N-1:0] t;
    t = N'((32'd1 << bar) - 1);
`ifdef PEAK_HOLD_EN
    if (bar > 0 && bar >= pk_cur) begin
      pk_set = bar;
      since  = 0;
    end else begin
      since++;
    end
    if (since <= HOLD) pk_cur = pk_set;
    else pk_cur = pk_set - (since - HOLD) * DEC;
    if (pk_cur < 0) pk_cur = 0;
    exp_led = t;
    if (pk_cur > 0) exp_led[pk_cur-1] = 1'b1;
    exp_pk = pk_cur;
`else
    exp_led = t;
    exp_pk  = 0;
`endif
  endfunction

  // One frame: samples from samp_q, a newClock rise, optional sample on the tick cycle.
  task automatic run_frame(input string tag, input int tick_level);
    int           fmax;
    int           lv;
    logic [N-1:0] prev_led;
    int           prev_pk;
    fmax     = 0;
    prev_led = exp_led;
    prev_pk  = exp_pk;
    newClock = 1'b0;
    repeat (3) step();
    while (samp_q.size() > 0) begin
      lv = samp_q.pop_front();
      repeat ($urandom_range(2, 0)) step();
      level      = W'(lv);
      levelValid = 1'b1;
      if (lv > fmax) fmax = lv;
      step();
      levelValid = 1'b0;
      level      = W'($urandom);
      checks++;
      if (tickPulse !== 1'b0) $display("FAIL %s stray_tick: tickPulse=%b want 0", tag, tickPulse);
      else passed++;
    end
    newClock = 1'b1;
    step();
    step();
    checks++;
    if (tickPulse !== 1'b0) $display("FAIL %s tick_early: tickPulse=%b want 0", tag, tickPulse);
    else passed++;
    step();
    checks++;
    if (tickPulse !== 1'b1) $display("FAIL %s tick_missing: tickPulse=%b want 1", tag, tickPulse);
    else passed++;
    if (tick_level >= 0) begin
      level      = W'(tick_level);
      levelValid = 1'b1;
      if (tick_level > fmax) fmax = tick_level;
    end
    step();
    levelValid = 1'b0;
    checks++;
    if (tickPulse !== 1'b0) $display("FAIL %s tick_width: tickPulse=%b want 0", tag, tickPulse);
    else passed++;
    checks++;
    if (ledBar !== prev_led || peakIndex !== 4'(prev_pk))
      $display("FAIL %s hold: ledBar=%h peakIndex=%0d want %h %0d",
               tag, ledBar, peakIndex, prev_led, prev_pk);
    else passed++;
    model_frame(bar_of(fmax));
    step();
    checks++;
    if (ledBar !== exp_led) $display("FAIL %s ledBar: got %h want %h", tag, ledBar, exp_led);
    else passed++;
    checks++;
    if (peakIndex !== 4'(exp_pk))
      $display("FAIL %s peakIndex: got %0d want %0d", tag, peakIndex, exp_pk);
    else passed++;
    newClock = 1'b0;
  endtask

  task automatic do_reset(input string tag, input logic nc);
    reset      = 1'b1;
    newClock   = nc;
    levelValid = 1'b0;
    step();
    step();
    checks++;
    if (tickPulse !== 1'b0 || ledBar !== '0 || peakIndex !== '0)
      $display("FAIL %s reset_state: tick=%b ledBar=%h peakIndex=%0d want 0 000 0",
               tag, tickPulse, ledBar, peakIndex);
    else passed++;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    int ticks;
    ticks = 0;
    do_reset("reset", 1'b1);
    repeat (100) begin
      step();
      if (tickPulse === 1'b1) ticks++;
    end
    checks++;
    if (ticks != 0) $display("FAIL idle_high_ticks: got %0d ticks want 0", ticks);
    else passed++;
    checks++;
    if (ledBar !== '0 || peakIndex !== '0)
      $display("FAIL idle_high_outputs: ledBar=%h peakIndex=%0d want 000 0", ledBar, peakIndex);
    else passed++;
  endtask

  task automatic test_full_scale();
    samp_q.push_back(255);
    run_frame("full_scale", -1);
  endtask

  task automatic test_frame_max();
    do_reset("frame_max_rst", 1'b0);
    samp_q.push_back(40);
    samp_q.push_back(200);
    samp_q.push_back(90);
    run_frame("frame_max", -1);
    run_frame("frame_max_empty", -1);
  endtask

  task automatic test_hold_decay();
    do_reset("decay_rst", 1'b0);
    samp_q.push_back(255);
    run_frame("decay_load", -1);
    for (int f = 1; f <= 13; f++) run_frame($sformatf("decay_f%0d", f), -1);
    samp_q.push_back(30);
    run_frame("decay_after_idle", -1);
  endtask

  task automatic test_tick_sample();
    do_reset("tick_sample_rst", 1'b0);
    run_frame("tick_sample", 250);
    run_frame("tick_sample_next", -1);
  endtask

  task automatic test_reset_in_decay();
    do_reset("mid_rst_pre", 1'b0);
    samp_q.push_back(255);
    run_frame("mid_load", -1);
    for (int f = 1; f <= 7; f++) run_frame($sformatf("mid_f%0d", f), -1);
    // Tick is in flight when reset hits.
    repeat (3) step();
    newClock = 1'b1;
    step();
    step();
    reset = 1'b1;
    step();
    checks++;
    if (tickPulse !== 1'b0 || ledBar !== '0 || peakIndex !== '0)
      $display("FAIL mid_reset: tick=%b ledBar=%h peakIndex=%0d want 0 000 0",
               tickPulse, ledBar, peakIndex);
    else passed++;
    step();
    reset = 1'b0;
    model_reset();
    repeat (4) step();
    checks++;
    if (tickPulse !== 1'b0) $display("FAIL mid_reset_discard: tickPulse=%b want 0", tickPulse);
    else passed++;
    samp_q.push_back(128);
    run_frame("post_reset_128", -1);
  endtask

  task automatic test_random();
    int n;
    int tl;
    do_reset("random_rst", 1'b0);
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(5, 0);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(3, 0) == 0) samp_q.push_back(0);
        else samp_q.push_back($urandom_range(255, 0));
      end
      tl = ($urandom_range(3, 0) == 0) ? int'($urandom_range(255, 0)) : -1;
      run_frame($sformatf("random_f%0d", f), tl);
    end
  endtask

  initial begin
    reset      = 1'b1;
    newClock   = 1'b1;
    level      = '0;
    levelValid = 1'b0;
    model_reset();
    test_reset();
    test_full_scale();
    test_frame_max();
    test_hold_decay();
    test_tick_sample();
    test_reset_in_decay();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
